// File: rtl/spi_txn_sequencer_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
package spi_txn_pkg;
  localparam int SPI_MAX_BYTES = 4;
  localparam int BCNT_W        = 3;
  localparam int DATA_W        = SPI_MAX_BYTES * 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_XFER  = 3'd2,
    S_GAP   = 3'd3,
    S_RESP  = 3'd4
  } state_t;
endpackage

// File: rtl/spi_txn_sequencer_byte_mask.sv
// Byte count -> byte-lane mask; lanes at index >= count are cleared.
module spi_byte_mask
  import spi_txn_pkg::*;
(
  input  logic [BCNT_W-1:0] count,
  output logic [DATA_W-1:0] mask
);
  for (genvar i = 0; i < SPI_MAX_BYTES; i++) begin : g_lane
    assign mask[i*8 +: 8] = {8{count > BCNT_W'(i)}};
  end
endmodule

// File: rtl/spi_txn_sequencer.sv
// Sequences one 1-4 byte SPI transfer per request: setup, enabled transfer
// with timeout, enforced idle gap, then a held valid/ready response.
module spi_txn_sequencer
  import spi_txn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [BCNT_W-1:0] req_bytes_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_error_o,
  output logic              spi_enable_o,
  output logic [DATA_W-1:0] spi_write_data_o,
  output logic [BCNT_W-1:0] spi_write_data_bytes_valid_o,
  input  logic [DATA_W-1:0] spi_read_data_i,
  input  logic [BCNT_W-1:0] spi_read_data_bytes_valid_i,
  output logic              busy_o
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t            state, nxt;
  logic [BCNT_W-1:0] count_q, wbytes_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, wmask, rmask;
  logic              enable_q, rsp_valid_q, rerr_q;
  logic [TW-1:0]     tcnt;
  logic [GW-1:0]     gcnt;
  logic              legal, done, tmo;

  spi_byte_mask u_wmask (.count(req_bytes_i), .mask(wmask));
  spi_byte_mask u_rmask (.count(count_q),     .mask(rmask));

  assign legal = (req_bytes_i != '0) && (req_bytes_i <= BCNT_W'(SPI_MAX_BYTES));
  assign done  = (spi_read_data_bytes_valid_i == count_q);
  // Completion is checked first wherever both are used, so it wins a tie.
  assign tmo   = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (req_valid_i) nxt = legal ? S_SETUP : S_RESP;
      S_SETUP: nxt = S_XFER;
      S_XFER:  if (done || tmo) nxt = (GAP_CYCLES == 0) ? S_RESP : S_GAP;
      S_GAP:   if (gcnt == GW'(GAP_CYCLES - 1)) nxt = S_RESP;
      S_RESP:  if (rsp_ready_i) nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      count_q     <= '0;
      wbytes_q    <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rerr_q      <= 1'b0;
      enable_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      tcnt        <= '0;
      gcnt        <= '0;
    end else begin
      state       <= nxt;
      enable_q    <= (nxt == S_XFER);
      rsp_valid_q <= (nxt == S_RESP);
      case (state)
        S_IDLE: if (req_valid_i) begin
          count_q <= req_bytes_i;
          if (legal) begin
            wdata_q  <= req_data_i & wmask;
            wbytes_q <= req_bytes_i;
          end else begin
            rdata_q <= '0;
            rerr_q  <= 1'b1;
          end
        end
        S_SETUP: tcnt <= '0;
        S_XFER: begin
          tcnt <= tcnt + TW'(1);
          if (done) begin
            rdata_q <= spi_read_data_i & rmask;
            rerr_q  <= 1'b0;
          end else if (tmo) begin
            rdata_q <= '0;
            rerr_q  <= 1'b1;
          end
          if (done || tmo) begin
            wdata_q  <= '0;
            wbytes_q <= '0;
            gcnt     <= '0;
          end
        end
        S_GAP: gcnt <= gcnt + GW'(1);
        S_RESP: if (rsp_ready_i) begin
          rdata_q <= '0;
          rerr_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Ready is forced low during reset even though the state already reads IDLE.
  assign req_ready_o                  = (state == S_IDLE) && !rst_i;
  assign busy_o                       = (state != S_IDLE);
  assign rsp_valid_o                  = rsp_valid_q;
  assign rsp_data_o                   = rdata_q;
  assign rsp_error_o                  = rerr_q;
  assign spi_enable_o                 = enable_q;
  assign spi_write_data_o             = wdata_q;
  assign spi_write_data_bytes_valid_o = wbytes_q;
endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Table-driven and randomized checks of spi_txn_sequencer against a transaction-level model.
module tb_spi_txn_sequencer;
  logic        clk = 0, rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_error, spi_enable, busy;
  logic [31:0] req_data, rsp_data, spi_wdata, m_rdata;
  logic [2:0]  req_bytes, spi_wbytes, m_bv;
  int          lat, en_seen;

  logic        t_req_valid, t_req_ready, t_rsp_valid, t_rsp_ready, t_rsp_error, t_enable, t_busy;
  logic [31:0] t_req_data, t_rsp_data, t_wdata;
  logic [2:0]  t_req_bytes, t_wbytes;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  spi_txn_sequencer dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_data_i(req_data), .req_bytes_i(req_bytes), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_error_o(rsp_error),
    .spi_enable_o(spi_enable), .spi_write_data_o(spi_wdata),
    .spi_write_data_bytes_valid_o(spi_wbytes), .spi_read_data_i(m_rdata),
    .spi_read_data_bytes_valid_i(m_bv), .busy_o(busy));

  // Second instance with a short timeout and a master that never finishes.
  spi_txn_sequencer #(.TIMEOUT_CYCLES(16), .GAP_CYCLES(4)) dut_to (
    .clk_i(clk), .rst_i(rst), .req_valid_i(t_req_valid), .req_ready_o(t_req_ready),
    .req_data_i(t_req_data), .req_bytes_i(t_req_bytes), .rsp_valid_o(t_rsp_valid),
    .rsp_ready_i(t_rsp_ready), .rsp_data_o(t_rsp_data), .rsp_error_o(t_rsp_error),
    .spi_enable_o(t_enable), .spi_write_data_o(t_wdata),
    .spi_write_data_bytes_valid_o(t_wbytes), .spi_read_data_i(32'hCAFEF00D),
    .spi_read_data_bytes_valid_i(3'd0), .busy_o(t_busy));

  // Master model: reports completion once enable has been high for lat cycles.
  always @(posedge clk) en_seen <= spi_enable ? en_seen + 1 : 0;
  assign m_bv = (spi_enable && en_seen >= lat) ? spi_wbytes : 3'd0;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rsp;
    logic        exp_err;
    int          exp_en;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_mask(input int n);
    logic [63:0] m;
    m = (64'd1 << (8 * n)) - 64'd1;
    return m[31:0];
  endfunction

  // Transaction-level reference: what a legal/illegal request must produce.
  function automatic vec_t model(input logic [31:0] d, input logic [2:0] b, input int l,
                                 input logic [31:0] r);
    vec_t v;
    bit ok;
    ok = (b >= 1 && b <= 4);
    v.data = d; v.bytes = b; v.lat = l; v.rdata = r;
    v.exp_wdata = ok ? (d & lane_mask(b)) : 32'h0;
    v.exp_rsp   = ok ? (r & lane_mask(b)) : 32'h0;
    v.exp_err   = !ok;
    v.exp_en    = ok ? l + 1 : 0;
    return v;
  endfunction

  // Issue at a negedge, follow the transfer, check everything, consume the response.
  task automatic run_txn(input vec_t v, input int hold);
    int en_hi, gap, bad, cyc;
    bit seen_en;
    en_hi = 0; gap = 0; bad = 0; seen_en = 0;
    lat = v.lat; m_rdata = v.rdata;
    req_valid = 1; req_data = v.data; req_bytes = v.bytes;
    chk("req_ready_idle", {31'b0, req_ready}, 1);
    @(negedge clk);
    req_valid = 0;
    if (v.exp_err && v.exp_en == 0) begin
      chk("illegal_rsp_next", {31'b0, rsp_valid}, 1);
      chk("illegal_no_en", {31'b0, spi_enable}, 0);
    end else begin
      chk("setup_en_low", {31'b0, spi_enable}, 0);
      chk("setup_wdata", spi_wdata, v.exp_wdata);
      chk("setup_wbytes", {29'b0, spi_wbytes}, {29'b0, v.bytes});
      for (cyc = 0; cyc < 300 && !rsp_valid; cyc++) begin
        @(negedge clk);
        if (spi_enable) begin
          seen_en = 1; en_hi++;
          if (spi_wdata !== v.exp_wdata || spi_wbytes !== v.bytes) bad++;
        end else if (seen_en && !rsp_valid) begin
          gap++;
          if (spi_wdata !== 0 || spi_wbytes !== 0) bad++;
        end
      end
      chk("rsp_arrived", {31'b0, rsp_valid}, 1);
      chk("en_high_cycles", en_hi, v.exp_en);
      chk("gap_cycles", gap, 4);
      chk("hold_and_clear", bad, 0);
    end
    chk("rsp_data", rsp_data, v.exp_rsp);
    chk("rsp_error", {31'b0, rsp_error}, {31'b0, v.exp_err});
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_data = 32'h5555AAAA; req_bytes = 3'd1;
      @(negedge clk);
      if (!rsp_valid || rsp_data !== v.exp_rsp || rsp_error !== v.exp_err || req_ready) bad++;
    end
    req_valid = 0;
    if (hold > 0) chk("backpressure_stable", bad, 0);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("turnaround_ready", {31'b0, req_ready}, 1);
    chk("rsp_dropped", {31'b0, rsp_valid}, 0);
    chk("not_busy", {31'b0, busy}, 0);
  endtask

  vec_t tbl[4];

  initial begin
    vec_t v;
    int   en_hi, cyc, bad;
    tbl[0] = '{32'hA1B2C3D4, 3'd4, 20, 32'h11223344, 32'hA1B2C3D4, 32'h11223344, 1'b0, 21};
    tbl[1] = '{32'hFFFFFFFF, 3'd2, 3,  32'hDEADBEEF, 32'h0000FFFF, 32'h0000BEEF, 1'b0, 4};
    tbl[2] = '{32'h12345678, 3'd0, 0,  32'h0,        32'h0,        32'h0,        1'b1, 0};
    tbl[3] = '{32'h12345678, 3'd6, 0,  32'h0,        32'h0,        32'h0,        1'b1, 0};

    rst = 1; req_valid = 0; req_data = 0; req_bytes = 0; rsp_ready = 0;
    m_rdata = 0; lat = 0; en_seen = 0;
    t_req_valid = 0; t_req_data = 0; t_req_bytes = 0; t_rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'b0, req_ready}, 0);
    chk("rst_enable", {31'b0, spi_enable}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_wdata", spi_wdata, 0);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 1);

    foreach (tbl[i]) run_txn(tbl[i], 0);

    // Response backpressure for 10 cycles; then a new request must go straight through.
    run_txn(model(32'h0BADCAFE, 3'd3, 5, 32'h99887766), 10);
    run_txn(model(32'h76543210, 3'd1, 2, 32'h000000AB), 0);

    for (int n = 0; n < 20; n++)
      run_txn(model($urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 30), $urandom), 0);

    // Timeout: enable stays up exactly TIMEOUT_CYCLES cycles.
    t_req_valid = 1; t_req_data = 32'h12345678; t_req_bytes = 3'd3;
    @(negedge clk);
    t_req_valid = 0;
    en_hi = 0;
    for (cyc = 0; cyc < 200 && !t_rsp_valid; cyc++) begin
      @(negedge clk);
      if (t_enable) en_hi++;
    end
    chk("to_rsp_arrived", {31'b0, t_rsp_valid}, 1);
    chk("to_en_cycles", en_hi, 16);
    chk("to_error", {31'b0, t_rsp_error}, 1);
    chk("to_data", t_rsp_data, 0);
    t_rsp_ready = 1;
    @(negedge clk);
    t_rsp_ready = 0;
    chk("to_ready_after", {31'b0, t_req_ready}, 1);

    // Reset in the fifth XFER cycle abandons the transaction silently.
    lat = 100; m_rdata = 32'h01020304;
    req_valid = 1; req_data = 32'hF0F0F0F0; req_bytes = 3'd4;
    @(negedge clk);
    req_valid = 0;
    en_hi = 0;
    for (cyc = 0; cyc < 20 && en_hi < 5; cyc++) begin
      @(negedge clk);
      if (spi_enable) en_hi++;
    end
    chk("rst_mid_reached", en_hi, 5);
    rst = 1;
    @(negedge clk);
    chk("rst_mid_en_drop", {31'b0, spi_enable}, 0);
    chk("rst_mid_ready_low", {31'b0, req_ready}, 0);
    chk("rst_mid_no_rsp", {31'b0, rsp_valid}, 0);
    rst = 0;
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, req_ready}, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid || spi_enable || busy) bad++;
    end
    chk("rst_mid_quiet", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
